ascensor_driver: RTL and testbench
==================================

// Module: ascensor_driver
// PURPOSE
//  Car-side driver for the elevator algorithm interface. It produces s, estado_inicial,
//  cambio_piso and esperar, and consumes the algorithm's estado_final.
//  It latches hall/car buttons into pending requests, tracks the current floor and moves
//  the car one floor per T_VIAJE. On arrival it holds doors for T_PUERTA and clears the request.
//  Sits between the button/motor pins and the floor-selection algorithm.
// PARAMETERS
//  N_PISOS   10  floors served, 0..N_PISOS-1; one s bit per floor (max 16)
//  T_VIAJE    8  clk cycles to travel one floor (>=2)
//  T_PUERTA  16  clk cycles doors stay open (>=2)
// PORTS
//  clk            in   1        single clock, all logic on posedge
//  rst_n          in   1        synchronous reset, active low
//  boton          in   N_PISOS  request pulses/levels, bit i = floor i
//  estado_final   in   4        target floor chosen by algorithm (combinational from s/estado_inicial)
//  s              out  N_PISOS  pending-request register
//  estado_inicial out  4        current floor of car
//  cambio_piso    out  1        1-cycle pulse when estado_inicial changes
//  esperar        out  1        high while doors open (PUERTA state)
//  subir          out  1        motor up, high while moving up
//  bajar          out  1        motor down, high while moving down
//  error          out  1        1-cycle pulse: algorithm returned an invalid target
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): s=0, estado_inicial=0, cambio_piso=0, esperar=0,
//   subir=bajar=0, error=0, timer=0, state=REPOSO. Reset mid-move/mid-door aborts at once.
//   Reset takes priority over every other event.
//  Request latch, every cycle: s <= (s | boton) & ~clr.
//   clr = one-hot of estado_inicial when entering PUERTA or while in PUERTA.
//   Clear beats set on the same bit; all other bits set normally.
//  FSM states: REPOSO, DECIDIR, MOVIENDO, PUERTA.
//  REPOSO: outputs idle. If s!=0, go to DECIDIR.
//   DECIDIR gives one settle cycle so estado_final reflects the current s.
//  DECIDIR: sample estado_final into objetivo.
//   invalid (objetivo>=N_PISOS or s[objetivo]==0): error=1 for 1 cycle, go to REPOSO
//    (retries next cycle).
//   objetivo==estado_inicial: go to PUERTA.
//   objetivo>estado_inicial: subir=1, timer=0, go to MOVIENDO.
//   objetivo<estado_inicial: bajar=1, timer=0, go to MOVIENDO.
//  MOVIENDO: timer counts 0..T_VIAJE-1.
//   At T_VIAJE-1: estado_inicial +/-1 and cambio_piso=1 in the following cycle, timer=0.
//   First floor change occurs exactly T_VIAJE cycles after entering MOVIENDO.
//   If new floor==objetivo: subir=bajar=0, go to PUERTA in the same cycle as cambio_piso.
//   Else keep moving. objetivo is not re-sampled during travel.
//   estado_inicial never leaves 0..N_PISOS-1; at an end floor the direction must already match.
//   If it would not (defensive), stop and go to REPOSO.
//  PUERTA: esperar=1, timer counts 0..T_PUERTA-1; s[estado_inicial] is held cleared.
//   A boton press on the current floor restarts timer to 0 and is not latched.
//   At T_PUERTA-1 go to REPOSO; esperar falls in that cycle.
//  subir and bajar are never high together. cambio_piso is never high outside MOVIENDO->next.
//  Width rules: timers are clog2(max(T_VIAJE,T_PUERTA)) bits.
//   Floor arithmetic is 4-bit unsigned, with no wrap ever produced.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with boton=10'h3FF -> s=0, estado_inicial=0, all outputs 0.
//  2 Travel up: at floor 0, boton[3]=1, model returns 3 -> subir=1;
//    cambio_piso pulses at +8,+16,+24 cycles after MOVIENDO with floors 1,2,3;
//    esperar=1 for 16 cycles; s[3]=0.
//  3 Same floor: at floor 5, press boton[5] -> DECIDIR, PUERTA with no motion.
//    Re-press at door cycle 10 -> esperar lasts 10+16 cycles total; s[5] never set.
//  4 Travel down plus latch: floor 7, target 2. Press boton[9] mid-travel -> s[9] set, car stops at 2.
//    Then DECIDIR picks 9 and subir asserts after the door closes.
//  5 Invalid target: s=10'h010, model returns 4'd12, then 4'd6 (s[6]=0) ->
//    error pulses, car stays put, no subir/bajar.
//  6 Reset mid-move: rst_n=0 during MOVIENDO at timer=4 ->
//    next cycle state REPOSO, estado_inicial=0, subir=0, s=0.

Source files
------------

// File: rtl/ascensor_if.sv
// Signal bundle between the car driver and the buttons/floor-selection side.
// The driver owns the master modport; the algorithm/pins side uses slave.
interface ascensor_if #(
    parameter int N_PISOS = 10
);
    logic [N_PISOS-1:0] boton;
    logic [3:0]         estado_final;
    logic [N_PISOS-1:0] s;
    logic [3:0]         estado_inicial;
    logic               cambio_piso;
    logic               esperar;
    logic               subir;
    logic               bajar;
    logic               error;

    modport master (
        input  boton,
        input  estado_final,
        output s,
        output estado_inicial,
        output cambio_piso,
        output esperar,
        output subir,
        output bajar,
        output error
    );

    modport slave (
        output boton,
        output estado_final,
        input  s,
        input  estado_inicial,
        input  cambio_piso,
        input  esperar,
        input  subir,
        input  bajar,
        input  error
    );
endinterface

// File: rtl/ascensor_driver.sv
// Elevator car driver: latches requests, moves one floor per T_VIAJE,
// holds doors for T_PUERTA and reports invalid targets from the algorithm.
module ascensor_driver #(
    parameter int N_PISOS  = 10,
    parameter int T_VIAJE  = 8,
    parameter int T_PUERTA = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    ascensor_if.master bus
);

    localparam int T_MAX = (T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA;
    localparam int TW    = (T_MAX > 2) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0]      T_V_END = TW'(T_VIAJE - 1);
    localparam logic [TW-1:0]      T_P_END = TW'(T_PUERTA - 1);
    localparam logic [3:0]         TOP     = 4'(N_PISOS - 1);
    localparam logic [4:0]         N_LIM   = 5'(N_PISOS);
    localparam logic [N_PISOS-1:0] ONE     = N_PISOS'(1);

    typedef enum logic [1:0] {
        REPOSO,
        DECIDIR,
        MOVIENDO,
        PUERTA
    } state_t;

    state_t             state_q, state_d;
    logic [N_PISOS-1:0] s_q, s_d;
    logic [3:0]         piso_q, piso_d;
    logic [3:0]         obj_q, obj_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               cambio_q, cambio_d;
    logic               esperar_q, esperar_d;
    logic               subir_q, subir_d;
    logic               bajar_q, bajar_d;
    logic               error_q, error_d;

    logic               ef_ok;
    logic               at_end;
    logic               hold_btn;
    logic [3:0]         piso_nxt;
    logic [N_PISOS-1:0] clr;

    // Target must be in range and correspond to a pending request.
    assign ef_ok = ({1'b0, bus.estado_final} < N_LIM) &&
                   (|(s_q & (ONE << bus.estado_final)));

    assign at_end = (subir_q && piso_q == TOP) ||
                    (bajar_q && piso_q == 4'd0) ||
                    (!subir_q && !bajar_q);

    assign hold_btn = |(bus.boton & (ONE << piso_q));

    assign piso_nxt = subir_q ? piso_q + 4'd1 : piso_q - 4'd1;

    always_comb begin
        state_d   = state_q;
        piso_d    = piso_q;
        obj_d     = obj_q;
        timer_d   = timer_q;
        cambio_d  = 1'b0;
        esperar_d = esperar_q;
        subir_d   = subir_q;
        bajar_d   = bajar_q;
        error_d   = 1'b0;

        unique case (state_q)
            REPOSO: begin
                esperar_d = 1'b0;
                subir_d   = 1'b0;
                bajar_d   = 1'b0;
                timer_d   = '0;
                if (|s_q) state_d = DECIDIR;
            end
            DECIDIR: begin
                obj_d   = bus.estado_final;
                timer_d = '0;
                if (!ef_ok) begin
                    error_d = 1'b1;
                    state_d = REPOSO;
                end else if (bus.estado_final == piso_q) begin
                    esperar_d = 1'b1;
                    state_d   = PUERTA;
                end else if (bus.estado_final > piso_q) begin
                    subir_d = 1'b1;
                    state_d = MOVIENDO;
                end else begin
                    bajar_d = 1'b1;
                    state_d = MOVIENDO;
                end
            end
            MOVIENDO: begin
                if (timer_q == T_V_END) begin
                    timer_d = '0;
                    if (at_end) begin
                        // Direction disagrees with the shaft end: stop safely.
                        subir_d = 1'b0;
                        bajar_d = 1'b0;
                        state_d = REPOSO;
                    end else begin
                        piso_d   = piso_nxt;
                        cambio_d = 1'b1;
                        if (piso_nxt == obj_q) begin
                            subir_d   = 1'b0;
                            bajar_d   = 1'b0;
                            esperar_d = 1'b1;
                            state_d   = PUERTA;
                        end
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            PUERTA: begin
                if (hold_btn) begin
                    timer_d = '0;
                end else if (timer_q == T_P_END) begin
                    timer_d   = '0;
                    esperar_d = 1'b0;
                    state_d   = REPOSO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = REPOSO;
            end
        endcase
    end

    // The served floor stays cleared on the way in and for the whole door time.
    always_comb begin
        clr = '0;
        if (state_d == PUERTA || state_q == PUERTA) clr = ONE << piso_d;
    end

    assign s_d = (s_q | bus.boton) & ~clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= REPOSO;
            s_q       <= '0;
            piso_q    <= '0;
            obj_q     <= '0;
            timer_q   <= '0;
            cambio_q  <= 1'b0;
            esperar_q <= 1'b0;
            subir_q   <= 1'b0;
            bajar_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            piso_q    <= piso_d;
            obj_q     <= obj_d;
            timer_q   <= timer_d;
            cambio_q  <= cambio_d;
            esperar_q <= esperar_d;
            subir_q   <= subir_d;
            bajar_q   <= bajar_d;
            error_q   <= error_d;
        end
    end

    assign bus.s              = s_q;
    assign bus.estado_inicial = piso_q;
    assign bus.cambio_piso    = cambio_q;
    assign bus.esperar        = esperar_q;
    assign bus.subir          = subir_q;
    assign bus.bajar          = bajar_q;
    assign bus.error          = error_q;

endmodule

// File: tb/tb_ascensor_driver.sv
// Directed scoreboard bench for ascensor_driver with a lowest-pending-floor
// algorithm model that can be overridden to return arbitrary targets.
module tb_ascensor_driver;

    localparam int N  = 10;
    localparam int TV = 8;
    localparam int TP = 16;

    typedef struct {
        int floor;
        int t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'd0;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q[$];

    ascensor_if #(.N_PISOS(N)) bus ();

    ascensor_driver #(
        .N_PISOS (N),
        .T_VIAJE (TV),
        .T_PUERTA(TP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.estado_final = 4'd0;
        if (force_en) begin
            bus.estado_final = force_val;
        end else begin
            for (int i = N - 1; i >= 0; i--)
                if (bus.s[i]) bus.estado_final = 4'(i);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic press(input int f);
        bus.boton = N'(1) << f;
        @(negedge clk);
        bus.boton = '0;
    endtask

    task automatic run_move(input string tag, input int from, input int to,
                            input int lat, input int inj, input int inj_t);
        int   budget;
        int   cnt;
        int   len;
        int   n;
        bit   both;
        bit   up;
        exp_t e;
        up = to > from;
        n  = up ? to - from : from - to;
        for (int k = 1; k <= n; k++) begin
            e.floor = up ? from + k : from - k;
            e.t     = k * TV;
            q.push_back(e);
        end
        budget = 0;
        while (!(bus.subir || bus.bajar) && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        chk({tag, "_start"}, 32'(budget < 60), 32'd1);
        if (lat >= 0) chk({tag, "_lat"}, 32'(budget), 32'(lat));
        chk({tag, "_dir"}, 32'({bus.subir, bus.bajar}),
            up ? 32'd2 : 32'd1);
        chk({tag, "_door_shut"}, 32'(bus.esperar), 32'd0);
        cnt  = 0;
        both = 0;
        while (q.size() > 0 && cnt < 300) begin
            @(negedge clk);
            cnt++;
            bus.boton = '0;
            if (cnt == inj_t) bus.boton = N'(1) << inj;
            if (bus.subir && bus.bajar) both = 1;
            if (bus.cambio_piso) begin
                e = q.pop_front();
                chk({tag, "_floor"}, 32'(bus.estado_inicial), 32'(e.floor));
                chk({tag, "_when"}, 32'(cnt), 32'(e.t));
            end
        end
        chk({tag, "_pending"}, 32'(q.size()), 32'd0);
        q.delete();
        chk({tag, "_both"}, 32'(both), 32'd0);
        chk({tag, "_esperar"}, 32'(bus.esperar), 32'd1);
        chk({tag, "_stopped"}, 32'({bus.subir, bus.bajar}), 32'd0);
        chk({tag, "_clr"}, 32'(bus.s[to]), 32'd0);
        if (inj >= 0) chk({tag, "_latched"}, 32'(bus.s[inj]), 32'd1);
        len = 0;
        while (bus.esperar && len < 100) begin
            len++;
            @(negedge clk);
        end
        chk({tag, "_door_len"}, 32'(len), 32'(TP));
    endtask

    task automatic err_window(input string tag);
        int  errs;
        bit  moved;
        errs  = 0;
        moved = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.error) errs++;
            if (bus.subir || bus.bajar || bus.esperar) moved = 1;
        end
        chk({tag, "_pulses"}, 32'(errs), 32'd10);
        chk({tag, "_moved"}, 32'(moved), 32'd0);
        chk({tag, "_floor"}, 32'(bus.estado_inicial), 32'd9);
        chk({tag, "_s"}, 32'(bus.s), 32'h010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  budget;
        int  len;
        bit  s5_seen;
        bit  motor;

        // 1: reset with all buttons held
        bus.boton = '1;
        repeat (3) @(negedge clk);
        chk("rst_s", 32'(bus.s), 32'd0);
        chk("rst_floor", 32'(bus.estado_inicial), 32'd0);
        chk("rst_outs", 32'({bus.cambio_piso, bus.esperar, bus.subir,
                              bus.bajar, bus.error}), 32'd0);
        rst_n     = 1'b1;
        bus.boton = '0;
        @(negedge clk);

        // 2: travel up 0 -> 3
        press(3);
        chk("up_latch", 32'(bus.s), 32'h008);
        run_move("up3", 0, 3, 2, -1, -1);

        press(5);
        run_move("up5", 3, 5, 2, -1, -1);

        // 3: same floor, door re-press at door cycle 10
        press(5);
        budget = 0;
        motor  = 0;
        while (!bus.esperar && budget < 20) begin
            if (bus.subir || bus.bajar) motor = 1;
            @(negedge clk);
            budget++;
        end
        chk("same_lat", 32'(budget), 32'd2);
        len     = 0;
        s5_seen = 0;
        while (bus.esperar && len < 100) begin
            len++;
            if (bus.s[5]) s5_seen = 1;
            if (bus.subir || bus.bajar) motor = 1;
            if (len == 10) bus.boton = N'(1) << 5;
            @(negedge clk);
            bus.boton = '0;
        end
        chk("same_door_len", 32'(len), 32'd26);
        chk("same_s5", 32'(s5_seen), 32'd0);
        chk("same_motor", 32'(motor), 32'd0);
        chk("same_floor", 32'(bus.estado_inicial), 32'd5);

        // 4: down 7 -> 2 with a floor-9 press in flight, then up to 9
        press(7);
        run_move("up7", 5, 7, 2, -1, -1);
        press(2);
        run_move("down2", 7, 2, 2, 9, 12);
        run_move("up9", 2, 9, 2, -1, -1);

        // 5: invalid targets from the algorithm
        force_en  = 1'b1;
        force_val = 4'd12;
        press(4);
        chk("inv_latch", 32'(bus.s), 32'h010);
        err_window("inv12");
        force_val = 4'd6;
        err_window("inv6");

        // 6: reset four cycles into a move
        force_en = 1'b0;
        budget   = 0;
        while (!(bus.subir || bus.bajar) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("rm_dir", 32'({bus.subir, bus.bajar}), 32'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rm_floor", 32'(bus.estado_inicial), 32'd0);
        chk("rm_s", 32'(bus.s), 32'd0);
        chk("rm_outs", 32'({bus.cambio_piso, bus.esperar, bus.subir,
                             bus.bajar, bus.error}), 32'd0);
        rst_n = 1'b1;
        motor = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.subir || bus.bajar || bus.esperar || bus.error) motor = 1;
        end
        chk("rm_idle", 32'(motor), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
